icache_fill_unit: RTL

//  Miss-fill engine directly downstream of the icache. Accepts line-miss requests
//  (req_vld/req_addr/req_rd), fetches the 32B line from the memory bus as four
//  64-bit beats, assembles it and returns it as one 256-bit write
//  (mem_data/mem_vld/mem_addr). A 2-entry request queue lets a split-line second

---
 rtl/icache_fill_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/icache_fill_unit.sv
// icache_fill_unit: miss-fill engine between the icache and the memory bus.
// Queues up to QDEPTH line misses, fetches each line as BEATS bus beats and
// returns the assembled line as a single wide write with a one-cycle strobe.
module icache_fill_unit #(
   parameter int ADDR_W = 15,
   parameter int BUS_W  = 64,
   parameter int BEATS  = 4,
   parameter int QDEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_vld,
   input  logic [ADDR_W-1:0]      req_addr,
   output logic                   req_rd,
   output logic [BEATS*BUS_W-1:0] mem_data,
   output logic                   mem_vld,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   bus_req,
   output logic [ADDR_W-1:0]      bus_addr,
   input  logic                   bus_gnt,
   input  logic                   bus_dvld,
   input  logic [BUS_W-1:0]       bus_data
);

   localparam int LINE_W = BEATS * BUS_W;
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int LA_W   = ADDR_W - OFF_W;
   localparam int CNT_W  = $clog2(QDEPTH + 1);
   localparam int BC_W   = $clog2(BEATS);
   localparam logic [CNT_W-1:0] Q_FULL    = CNT_W'(QDEPTH);
   localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_DONE} state_t;

   state_t            state;
   logic [LA_W-1:0]   q_line [QDEPTH];
   logic [CNT_W-1:0]  q_cnt;
   logic [LA_W-1:0]   fill_line;
   logic [BC_W-1:0]   beat_cnt;
   logic [BUS_W-1:0]  beat_buf [BEATS];
   logic [LA_W-1:0]   req_line;
   logic [LA_W-1:0]   start_line;
   logic [CNT_W-1:0]  wr_idx;
   logic [LINE_W-1:0] line_next;
   logic              dup, enq, deq, bypass, start;

   assign req_line = req_addr[ADDR_W-1:OFF_W];

   // Duplicate detection against valid queue entries and the line in flight
   always_comb begin
      dup = (state != S_IDLE) && (fill_line == req_line);
      for (int unsigned i = 0; i < QDEPTH; i++)
         if ((CNT_W'(i) < q_cnt) && (q_line[i] == req_line))
            dup = 1'b1;
   end

   // Acceptance, queue push/pop and fill-start decisions
   always_comb begin
      req_rd = req_vld && (dup || (q_cnt < Q_FULL));
      enq    = req_vld && !dup && (q_cnt < Q_FULL);
      deq    = (state == S_IDLE) && (q_cnt != '0);
      // An idle engine with an empty queue starts the new miss directly, so
      // bus_req rises the cycle after acceptance instead of two cycles later.
      bypass     = (state == S_IDLE) && (q_cnt == '0) && enq;
      start      = deq || bypass;
      start_line = deq ? q_line[0] : req_line;
      wr_idx     = deq ? (q_cnt - CNT_W'(1)) : q_cnt;
   end

   // Line assembly: beats captured so far plus the beat arriving now
   always_comb begin
      line_next = '0;
      for (int unsigned i = 0; i < BEATS; i++)
         line_next[i*BUS_W +: BUS_W] = (BC_W'(i) == beat_cnt) ? bus_data : beat_buf[i];
   end

   // Request queue, head at entry 0, entries shift toward the head on pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_cnt <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++)
            q_line[i] <= '0;
      end else begin
         if (deq)
            for (int unsigned i = 0; i + 1 < QDEPTH; i++)
               q_line[i] <= q_line[i+1];
         if (enq && !bypass)
            for (int unsigned i = 0; i < QDEPTH; i++)
               if (CNT_W'(i) == wr_idx)
                  q_line[i] <= req_line;
         case ({enq && !bypass, deq})
            2'b10:   q_cnt <= q_cnt + CNT_W'(1);
            2'b01:   q_cnt <= q_cnt - CNT_W'(1);
            default: q_cnt <= q_cnt;
         endcase
      end
   end

   // Fill sequencer with registered bus request and line-return outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         fill_line <= '0;
         beat_cnt  <= '0;
         for (int unsigned i = 0; i < BEATS; i++)
            beat_buf[i] <= '0;
         bus_req   <= 1'b0;
         bus_addr  <= '0;
         mem_vld   <= 1'b0;
         mem_data  <= '0;
         mem_addr  <= '0;
      end else begin
         mem_vld <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  fill_line <= start_line;
                  bus_addr  <= {start_line, OFF_W'(0)};
                  bus_req   <= 1'b1;
                  state     <= S_ARB;
               end
            end
            S_ARB: begin
               if (bus_gnt) begin
                  bus_req  <= 1'b0;
                  beat_cnt <= '0;
                  state    <= S_XFER;
               end
            end
            S_XFER: begin
               if (bus_dvld) begin
                  beat_buf[beat_cnt] <= bus_data;
                  beat_cnt           <= beat_cnt + BC_W'(1);
                  if (beat_cnt == LAST_BEAT) begin
                     mem_data <= line_next;
                     mem_addr <= {fill_line, OFF_W'(0)};
                     mem_vld  <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
